mul_arbiter: RTL
================

MUL_ARBITER -- requirements
Module: mul_arbiter

Interface
REQ-001 SHALL have parameter MUL_LAT, default 4, meaning fixed cycle count from operand capture to product on mul_r (range 1..15).
REQ-002 SHALL have parameter W, default 16, meaning operand width; the product is 2*W bits.
REQ-003 clk  in  1  sole clock; all state updates on the rising edge.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 hold  in  1  when high, no new issue is granted; in-flight operations continue.
REQ-006 req0_valid / req1_valid  in  1  requester 0/1 has an operand pair.
REQ-007 req0_a, req0_b / req1_a, req1_b  in  W  signed two's-complement operands.
REQ-008 req0_ready / req1_ready  out  1  grant; transfer occurs on an edge where valid and ready are both high.
REQ-009 mul_a, mul_b  out  W  registered operands to the shared multiplier.
REQ-010 mul_r  in  2W  multiplier product, valid MUL_LAT edges after mul_a/mul_b capture.
REQ-011 rsp0_valid / rsp1_valid  out  1  one-cycle product strobe per requester; no backpressure.
REQ-012 rsp0_r / rsp1_r  out  2W  product; equals mul_r.
REQ-013 inflight  out  4  count of issued, not yet returned operations.

Function
REQ-014 SHALL compute ready combinationally: at most one of req0_ready/req1_ready high per cycle, and both low when hold=1 or rst=1.
REQ-015 Arbitration SHALL be round-robin: with a single valid requester, that requester is granted; with both valid, the requester not granted most recently is granted.
REQ-016 The last-grant pointer SHALL update only on an accepted transfer; after reset it points to requester 1, so requester 0 wins the first tie.
REQ-017 An accepted transfer on edge k SHALL register its operands into mul_a/mul_b at edge k and push the requester ID plus a valid bit into stage 0 of the tag pipeline.
REQ-018 The tag pipeline SHALL have MUL_LAT stages and shift every cycle, including cycles with no transfer (bubbles carry valid=0).
REQ-019 rspN_valid SHALL be high for exactly the one cycle following edge k+MUL_LAT, where N is the ID carried by the tag, and low otherwise.
REQ-020 Throughput SHALL be one issue per cycle; back-to-back issues from either or alternating requesters SHALL return in issue order with no gaps added.
REQ-021 mul_a/mul_b SHALL hold their last value when no transfer occurs.
REQ-022 inflight SHALL increment on issue and decrement on tag retire; on a simultaneous issue and retire it SHALL be unchanged. Its maximum is MUL_LAT.
REQ-023 Asserting hold mid-stream SHALL NOT drop or delay already issued operations.

Reset
REQ-024 On rst: req0_ready, req1_ready, rsp0_valid and rsp1_valid are 0; mul_a, mul_b and inflight are 0; all tag-valid bits are 0; the last-grant pointer is 1.
REQ-025 Reset asserted with operations in flight SHALL discard them: no rspN_valid is produced for any issue made before the reset edge.
REQ-026 The first transfer SHALL be accepted on the first edge with rst=0, given valid=1 and hold=0.

Structure
REQ-027 Package mul_pkg SHALL hold the default MUL_LAT, W, the requester-ID type (1 bit) and the tag struct {valid, id}.
REQ-028 The tag delay line SHALL be a sub-module mul_tag_pipe (parameter depth MUL_LAT, input tag, output tag).
REQ-029 The multiplier SHALL be instantiated outside this block. The bench pairs the arbiter with the existing 16x16 signed multiplier at matching MUL_LAT.

Verification
REQ-030 Single requester: req0 issues 13001 x 2154 at edge k -> rsp0_valid high for one cycle after edge k+4, rsp0_r = 28004154, and rsp1_valid stays 0.
REQ-031 Tie: both valid every cycle, req0 = 5 x 7 and req1 = 2 x 3 -> grants alternate 0,1,0,1; responses alternate 35, 6, 35, 6 with one response every cycle.
REQ-032 Signed operands: req1 issues -6 x 10 -> rsp1_r = 32'hFFFF_FFC4.
REQ-033 Hold: issue 3 back-to-back, then hold=1 for 5 cycles -> both readys stay 0, all 3 responses return, inflight goes 3 then 0.
REQ-034 Reset mid-flight: issue 2 operations, then pulse rst 2 cycles later -> no rsp strobes for them, inflight = 0, and the next tie grants requester 0.
REQ-035 Zero product: 0 x 0 from req0 -> rsp0_valid asserted with rsp0_r = 0, which checks that valid is independent of product value.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared defaults and tag types for the round-robin multiplier front end.
package mul_pkg;

  localparam int unsigned MulLatDefault = 4;
  localparam int unsigned WDefault      = 16;

  typedef logic req_id_t;

  typedef struct packed {
    logic    valid;
    req_id_t id;
  } tag_t;

endpackage

// File: rtl/mul_tag_pipe.sv
// Fixed-depth delay line carrying requester tags alongside the external multiplier.
module mul_tag_pipe
  import mul_pkg::*;
#(
  parameter int unsigned Depth = MulLatDefault
) (
  input  logic clk,
  input  logic rst,
  input  tag_t tag_i,
  output tag_t tag_o
);

  tag_t stage_q [Depth];

  // Shifts every cycle so bubbles keep responses aligned with mul_r.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= tag_i;
      for (int unsigned i = 1; i < Depth; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign tag_o = stage_q[Depth-1];

endmodule

// File: rtl/mul_arbiter.sv
// Two-requester round-robin front end for a shared pipelined signed multiplier.
module mul_arbiter
  import mul_pkg::*;
#(
  parameter int unsigned MUL_LAT = MulLatDefault,
  parameter int unsigned W       = WDefault
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           hold,
  input  logic           req0_valid,
  input  logic [W-1:0]   req0_a,
  input  logic [W-1:0]   req0_b,
  input  logic           req1_valid,
  input  logic [W-1:0]   req1_a,
  input  logic [W-1:0]   req1_b,
  output logic           req0_ready,
  output logic           req1_ready,
  output logic [W-1:0]   mul_a,
  output logic [W-1:0]   mul_b,
  input  logic [2*W-1:0] mul_r,
  output logic           rsp0_valid,
  output logic           rsp1_valid,
  output logic [2*W-1:0] rsp0_r,
  output logic [2*W-1:0] rsp1_r,
  output logic [3:0]     inflight
);

  logic         gnt0, gnt1, issue, retire;
  req_id_t      last_q, last_d;
  logic [W-1:0] mul_a_q, mul_b_q;
  logic         rsp0_valid_q, rsp1_valid_q;
  logic [3:0]   inflight_q, inflight_d;
  tag_t         tag_in, tag_out;

  // last_q == 1 means requester 1 won most recently, so requester 0 wins a tie.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst && !hold) begin
      if (req0_valid && (!req1_valid || last_q == 1'b1)) begin
        gnt0 = 1'b1;
      end else if (req1_valid) begin
        gnt1 = 1'b1;
      end
    end
  end

  assign issue  = gnt0 | gnt1;
  assign last_d = issue ? req_id_t'(gnt1) : last_q;
  assign tag_in = '{valid: issue, id: gnt1};
  assign retire = tag_out.valid;

  always_comb begin
    inflight_d = inflight_q;
    unique case ({issue, retire})
      2'b10:   inflight_d = inflight_q + 4'd1;
      2'b01:   inflight_d = inflight_q - 4'd1;
      default: inflight_d = inflight_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q       <= 1'b1;
      mul_a_q      <= '0;
      mul_b_q      <= '0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      inflight_q   <= '0;
    end else begin
      last_q       <= last_d;
      inflight_q   <= inflight_d;
      rsp0_valid_q <= retire && (tag_out.id == 1'b0);
      rsp1_valid_q <= retire && (tag_out.id == 1'b1);
      if (gnt0) begin
        mul_a_q <= req0_a;
        mul_b_q <= req0_b;
      end else if (gnt1) begin
        mul_a_q <= req1_a;
        mul_b_q <= req1_b;
      end
    end
  end

  mul_tag_pipe #(
    .Depth (MUL_LAT)
  ) u_tag_pipe (
    .clk   (clk),
    .rst   (rst),
    .tag_i (tag_in),
    .tag_o (tag_out)
  );

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign mul_a      = mul_a_q;
  assign mul_b      = mul_b_q;
  assign rsp0_valid = rsp0_valid_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp0_r     = mul_r;
  assign rsp1_r     = mul_r;
  assign inflight   = inflight_q;

endmodule
